// File: rtl/morse_key_capture.sv
// ============================================================================
// Module      : morse_key_capture
// Description : Debounces a raw Morse key, times each press as dot or dash,
//               packs up to five symbols per letter and pulses trans when the
//               inter-letter gap expires. The code is held through a fixed
//               window so the downstream translator can sample it. Error
//               status is reported on inf and held until clr.
//               Optional macro MORSE_BEEP_EN adds a key tone on beep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_key_capture #(
    parameter int CNT_W       = 28,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int DASH_CYCLES = 30_000_000,
    parameter int FAIL_CYCLES = 200_000_000,
    parameter int GAP_CYCLES  = 100_000_000,
    parameter int HOLD_CYCLES = 1_100_000
`ifdef MORSE_BEEP_EN
    ,
    parameter int BEEP_DIV    = 50_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       clr,
    output logic [4:0] led_morse,
    output logic [2:0] led_cnt,
    output logic       trans,
    output logic [1:0] inf,
    output logic       beep
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] FAIL_LAST = CNT_W'(FAIL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRESS = 3'd1,
        GAP   = 3'd2,
        HOLD  = 3'd3,
        ERR   = 3'd4
    } state_t;

    logic             sync1;
    logic             sync2;
    logic             deb_key;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_flip;
    logic             deb_rise;
    logic             deb_fall;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       morse_nx;
    logic [2:0]       lcnt_nx;
    logic [1:0]       inf_nx;
    logic             trans_nx;

    // Edge events are taken in the cycle the debounced level is about to flip,
    // so the FSM reacts on the same edge the debounced level changes.
    assign deb_flip = (sync2 != deb_key) && (deb_cnt == DEB_LAST);
    assign deb_rise = deb_flip &&  sync2;
    assign deb_fall = deb_flip && !sync2;
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Two-flop synchroniser followed by a stable-count debouncer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_key <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            if (sync2 != deb_key) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_key <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // FSM state, shared counter and registered letter outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            led_morse <= 5'd0;
            led_cnt   <= 3'd0;
            inf       <= 2'd0;
            trans     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            led_morse <= morse_nx;
            led_cnt   <= lcnt_nx;
            inf       <= inf_nx;
            trans     <= trans_nx;
        end
    end

    // Next-state and next-output logic; clr overrides every transition.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        morse_nx = led_morse;
        lcnt_nx  = led_cnt;
        inf_nx   = inf;
        trans_nx = 1'b0;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            morse_nx = 5'd0;
            lcnt_nx  = 3'd0;
            inf_nx   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (deb_rise) state_nx = PRESS;
                end
                PRESS: begin
                    cnt_nx = cnt_inc;
                    if (cnt == FAIL_LAST) begin
                        state_nx = ERR;
                        inf_nx   = 2'd2;
                    end else if (deb_fall) begin
                        if (led_cnt == 3'd5) begin
                            state_nx = ERR;
                            inf_nx   = 2'd1;
                        end else begin
                            morse_nx = {led_morse[3:0], (cnt >= DASH_MIN)};
                            lcnt_nx  = led_cnt + 3'd1;
                            state_nx = GAP;
                            cnt_nx   = '0;
                        end
                    end
                end
                GAP: begin
                    cnt_nx = cnt_inc;
                    // Expiry is checked first so a press in the expiry cycle is dropped.
                    if (cnt == GAP_LAST) begin
                        trans_nx = 1'b1;
                        state_nx = HOLD;
                        cnt_nx   = '0;
                    end else if (deb_rise) begin
                        state_nx = PRESS;
                        cnt_nx   = '0;
                    end
                end
                HOLD: begin
                    cnt_nx = cnt_inc;
                    if (cnt == HOLD_LAST) begin
                        morse_nx = 5'd0;
                        lcnt_nx  = 3'd0;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                ERR: begin
                    cnt_nx = '0;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

`ifdef MORSE_BEEP_EN
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_DIV - 1);

    logic [CNT_W-1:0] beep_cnt;
    logic             beep_q;
    logic             beep_act;

    assign beep_act = deb_key && ((state == IDLE) || (state == PRESS) || (state == GAP));
    assign beep     = beep_q;

    // Tone divider: toggles every BEEP_DIV cycles while the key is down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beep_cnt <= '0;
            beep_q   <= 1'b0;
        end else if (!beep_act) begin
            beep_cnt <= '0;
            beep_q   <= 1'b0;
        end else if (beep_cnt == BEEP_LAST) begin
            beep_cnt <= '0;
            beep_q   <= ~beep_q;
        end else begin
            beep_cnt <= beep_cnt + CNT_W'(1);
        end
    end
`else
    assign beep = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_morse_key_capture.sv
// ============================================================================
// Module      : tb_morse_key_capture
// Description : Self-checking bench for morse_key_capture with short timing
//               parameters (DEB=4, DASH=20, FAIL=100, GAP=50, HOLD=30).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_key_capture;

    localparam int DEB  = 4;
    localparam int DASH = 20;
    localparam int FAIL = 100;
    localparam int GAP  = 50;
    localparam int HOLD = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       clr;
    logic [4:0] led_morse;
    logic [2:0] led_cnt;
    logic       trans;
    logic [1:0] inf;
    logic       beep;

    int n_cmp = 0;
    int n_bad = 0;
    int trans_seen = 0;

    morse_key_capture #(
        .CNT_W      (28),
        .DEB_CYCLES (DEB),
        .DASH_CYCLES(DASH),
        .FAIL_CYCLES(FAIL),
        .GAP_CYCLES (GAP),
        .HOLD_CYCLES(HOLD)
`ifdef MORSE_BEEP_EN
        ,
        .BEEP_DIV   (3)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .clr      (clr),
        .led_morse(led_morse),
        .led_cnt  (led_cnt),
        .trans    (trans),
        .inf      (inf),
        .beep     (beep)
    );

    always #5 clk = ~clk;

    // Counts every cycle with trans high, sampled away from the active edge.
    always @(negedge clk) if (trans === 1'b1) trans_seen++;

    typedef struct {
        string      code;
        logic [4:0] morse;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int len);
        key = 1'b1;
        step(len);
        key = 1'b0;
    endtask

    // Keys a whole letter, then watches a bounded window for the trans pulse.
    task automatic run_letter(input string code, output int first, output int width,
                              output logic [4:0] m, output logic [2:0] c);
        for (int s = 0; s < code.len(); s++) begin
            press((code[s] == "-") ? 30 : 10);
            if (s != code.len() - 1) step(20);
        end
        first = 0;
        width = 0;
        m     = 5'd0;
        c     = 3'd0;
        for (int i = 1; i <= 110; i++) begin
            step(1);
            if (trans) begin
                if (width == 0) begin
                    first = i;
                    m     = led_morse;
                    c     = led_cnt;
                end
                width++;
            end
        end
    endtask

    initial begin
        int         first;
        int         width;
        int         t0;
        int         toggles;
        logic       prev;
        logic [4:0] m;
        logic [2:0] c;

        tbl[0] = '{code: ".-",    morse: 5'b00001, cnt: 3'd2};
        tbl[1] = '{code: "-.",    morse: 5'b00010, cnt: 3'd2};
        tbl[2] = '{code: ".----", morse: 5'b01111, cnt: 3'd5};
        tbl[3] = '{code: ".",     morse: 5'b00000, cnt: 3'd1};
        tbl[4] = '{code: "-",     morse: 5'b00001, cnt: 3'd1};
        tbl[5] = '{code: "-----", morse: 5'b11111, cnt: 3'd5};

        rst = 1'b0;
        key = 1'b0;
        clr = 1'b0;
        step(3);
        chk("reset led_morse", led_morse, 0);
        chk("reset led_cnt", led_cnt, 0);
        chk("reset trans", trans, 0);
        chk("reset inf", inf, 0);
        chk("reset beep", beep, 0);
        rst = 1'b1;
        step(5);

        // Letter A with exact trans timing and hold window.
        press(10);
        step(20);
        press(30);
        first = 0;
        width = 0;
        for (int i = 1; i <= 120; i++) begin
            step(1);
            if (trans) begin
                if (width == 0) begin
                    first = i;
                    chk("A led_morse at trans", led_morse, 1);
                    chk("A led_cnt at trans", led_cnt, 2);
                end
                width++;
            end
            if (i == 85) chk("A hold frozen led_cnt", led_cnt, 2);
            if (i == 86) chk("A hold cleared led_cnt", led_cnt, 0);
        end
        chk("A trans latency", first, GAP + DEB + 2);
        chk("A trans width", width, 1);

        // Table of letters.
        foreach (tbl[k]) begin
            run_letter(tbl[k].code, first, width, m, c);
            chk($sformatf("tbl%0d trans width", k), width, 1);
            chk($sformatf("tbl%0d led_morse", k), m, tbl[k].morse);
            chk($sformatf("tbl%0d led_cnt", k), c, tbl[k].cnt);
            chk($sformatf("tbl%0d cleared", k), led_cnt, 0);
        end

        // Single-cycle glitch must be rejected.
        t0  = trans_seen;
        key = 1'b1;
        step(1);
        key = 1'b0;
        step(80);
        chk("glitch led_cnt", led_cnt, 0);
        chk("glitch no trans", trans_seen - t0, 0);

        // Six symbols overflow the letter.
        t0 = trans_seen;
        for (int s = 0; s < 6; s++) begin
            press(10);
            step(20);
        end
        chk("overflow inf", inf, 1);
        chk("overflow led_cnt", led_cnt, 5);
        chk("overflow led_morse", led_morse, 0);
        step(80);
        chk("overflow inf held", inf, 1);
        chk("overflow no trans", trans_seen - t0, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr inf", inf, 0);
        chk("clr led_cnt", led_cnt, 0);

        // Overlong press after one dot.
        t0 = trans_seen;
        press(10);
        step(20);
        key = 1'b1;
        step(20);
        toggles = 0;
        prev    = beep;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (beep != prev) toggles++;
            prev = beep;
        end
`ifdef MORSE_BEEP_EN
        chk("beep toggles while pressed", toggles, 4);
`else
        chk("beep toggles while pressed", toggles, 0);
        chk("beep level while pressed", beep, 0);
`endif
        step(FAIL + DEB + 1 - 32);
        chk("fail inf before limit", inf, 0);
        step(1);
        chk("fail inf at limit", inf, 2);
        chk("fail led_cnt", led_cnt, 1);
        step(150 - (FAIL + DEB + 2));
        key = 1'b0;
        step(80);
        chk("fail inf held", inf, 2);
        chk("fail no trans", trans_seen - t0, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("fail clr inf", inf, 0);

        // Key held through HOLD is not counted.
        press(10);
        first = 0;
        for (int i = 1; i <= 100 && first == 0; i++) begin
            step(1);
            if (trans) first = i;
        end
        chk("hold trans seen", first, GAP + DEB + 2);
        key = 1'b1;
        step(HOLD - 1);
        chk("hold frozen led_cnt", led_cnt, 1);
        step(1);
        chk("hold cleared led_cnt", led_cnt, 0);
        step(40);
        chk("hold no new symbol", led_cnt, 0);
        t0  = trans_seen;
        key = 1'b0;
        step(60);
        chk("hold release no symbol", led_cnt, 0);
        chk("hold release no trans", trans_seen - t0, 0);
        press(10);
        step(10);
        chk("repress counted", led_cnt, 1);
        step(100);

        // Asynchronous reset in the middle of a gap.
        press(10);
        step(20);
        press(10);
        step(20);
        press(10);
        step(10);
        chk("pre-reset led_cnt", led_cnt, 3);
        t0 = trans_seen;
        #2;
        rst = 1'b0;
        #1;
        chk("async reset led_cnt", led_cnt, 0);
        chk("async reset led_morse", led_morse, 0);
        chk("async reset inf", inf, 0);
        step(2);
        rst = 1'b1;
        step(80);
        chk("post-reset no trans", trans_seen - t0, 0);
        chk("post-reset led_cnt", led_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
